uart_tx_buf: RTL and testbench



---
 rtl/uart_tx_buf.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a
// start/data/stop serializer so bursts never stall the producer.
module uart_tx_buf #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CNT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud;
    logic [CW-1:0] baud_next;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [7:0]    sh;
    logic [7:0]    sh_next;

    logic          wr_ok;
    logic          pop;
    logic          bit_end;
    logic          tx_next;

    // A strobe is stored only when there is room; a pop never frees
    // space for a write in the same cycle.
    assign wr_ok   = tx_en & ~fifo_full;
    assign bit_end = (baud == BAUD_LAST);

    // Occupancy: a write and a pop together cancel out.
    always_comb begin
        count_next = count;
        if (wr_ok && !pop) begin
            count_next = count + 1'b1;
        end else if (!wr_ok && pop) begin
            count_next = count - 1'b1;
        end
    end

    // Serializer next state, baud/bit counters and FIFO pop.
    always_comb begin
        state_next = state;
        baud_next  = baud + 1'b1;
        idx_next   = idx;
        sh_next    = sh;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                baud_next = '0;
                if (count != '0) begin
                    pop        = 1'b1;
                    sh_next    = mem[rd_ptr];
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    idx_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (count != '0) begin
                        pop        = 1'b1;
                        sh_next    = mem[rd_ptr];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                baud_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so tx is a plain flop.
    always_comb begin
        tx_next = 1'b1;
        unique case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = sh_next[idx_next];
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    // Byte storage; contents need no reset since count gates reads.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && wr_ok) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap on their own width.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Serializer state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            state <= state_next;
            baud  <= baud_next;
            idx   <= idx_next;
            sh    <= sh_next;
        end
    end

    // Registered outputs, derived from next-cycle values so they
    // track the state and count without an extra cycle of lag.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx        <= 1'b1;
            busy      <= 1'b0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            tx        <= tx_next;
            busy      <= (state_next != IDLE) | (count_next != '0);
            fifo_full <= (count_next == FULL_CNT);
            overflow  <= tx_en & fifo_full;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: frame-level reference model,
// per-cycle output compare, line decoder and directed scenarios.
module tb_uart_tx_buf;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 4;
    localparam int BITC     = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * BITC;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    uart_tx_buf #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .DEPTH   (DEPTH)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx       (tx),
        .busy     (busy),
        .fifo_full(fifo_full),
        .overflow (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_strobe = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: byte queue plus position inside the current frame.
    logic [7:0] mq[$];
    logic [7:0] acc_q[$];
    logic [7:0] mcur = 8'h00;
    int         mpos = -1;
    int         msz;
    bit         mpop;
    bit         mvalid = 1'b0;
    logic       e_tx = 1'b1;
    logic       e_busy = 1'b0;
    logic       e_full = 1'b0;
    logic       e_ovf = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        int k;
        if (pos < 0) return 1'b1;
        k = pos / BITC;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            mq.delete();
            mpos   = -1;
            e_ovf  = 1'b0;
            mvalid = 1'b1;
        end else begin
            msz   = mq.size();
            mpop  = (msz > 0) && (mpos < 0 || mpos == FRAME - 1);
            e_ovf = tx_en && (msz == DEPTH);
            if (mpos >= 0) mpos = (mpos == FRAME - 1) ? -1 : mpos + 1;
            if (mpop) begin
                mcur = mq.pop_front();
                mpos = 0;
            end
            if (tx_en && msz < DEPTH) begin
                mq.push_back(tx_data);
                acc_q.push_back(tx_data);
            end
        end
        e_full = (mq.size() == DEPTH);
        e_busy = (mpos >= 0) || (mq.size() > 0);
        e_tx   = frame_bit(mcur, mpos);
    end

    always @(negedge sys_clk) begin
        if (mvalid) begin
            check("cmp_tx", tx, e_tx);
            check("cmp_busy", busy, e_busy);
            check("cmp_full", fifo_full, e_full);
            check("cmp_ovf", overflow, e_ovf);
        end
    end

    // Line decoder: samples each bit mid-period after a falling start.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    bit         rx_act = 1'b0;
    int         rx_ph = 0;

    always @(negedge sys_clk) begin
        if (busy !== 1'b1) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx == 1'b0) begin
                rx_act = 1'b1;
                rx_ph  = 0;
            end
        end else begin
            rx_ph++;
            if (rx_ph >= 15 && rx_ph <= 85 && (rx_ph - 15) % 10 == 0)
                rx_sh[(rx_ph-15)/10] = tx;
            if (rx_ph == 95) begin
                check("rx_stop", tx, 1);
                rx_q.push_back(rx_sh);
            end
            if (rx_ph == FRAME - 1) rx_act = 1'b0;
        end
    end

    int ovf_cnt = 0;
    bit full_seen = 1'b0;
    bit ovf_arm = 1'b0;

    always @(negedge sys_clk) begin
        if (ovf_arm) begin
            if (overflow) ovf_cnt++;
            if (fifo_full) full_seen = 1'b1;
        end
    end

    task automatic send_burst(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            tx_en   = 1'b1;
            tx_data = base + 8'(i);
            if (i == 0) t_strobe = cyc + 1;
        end
        @(negedge sys_clk);
        tx_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound,
                             input int exp_k);
        int k = 0;
        while (busy && k < bound) begin
            @(negedge sys_clk);
            k++;
        end
        check(name, cyc - t_strobe, exp_k);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp);
        if (rx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no byte expected %0h", name, exp);
        end else begin
            check(name, rx_q.pop_front(), exp);
        end
    endtask

    logic tr_tx   [105];
    logic tr_busy [105];
    logic ab      [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int   low_cnt;
    int   w;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        repeat (2) @(negedge sys_clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", fifo_full, 0);
        check("rst_ovf", overflow, 0);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Single byte 0xA5 with a traced line.
        send_burst(1, 8'hA5);
        check("one_k0_tx", tx, 1);
        check("one_busy_rise", busy, 1);
        for (int j = 0; j < 105; j++) begin
            @(negedge sys_clk);
            tr_tx[j]   = tx;
            tr_busy[j] = busy;
        end
        check("one_start_first", tr_tx[0], 0);
        check("one_start_last", tr_tx[9], 0);
        for (int i = 0; i < 8; i++) begin
            check("one_bit_first", tr_tx[10+10*i], ab[i]);
            check("one_bit_last", tr_tx[19+10*i], ab[i]);
        end
        check("one_stop_first", tr_tx[90], 1);
        check("one_stop_last", tr_tx[99], 1);
        check("one_busy_end", tr_busy[99], 1);
        check("one_busy_fall", tr_busy[100], 0);
        check_rx("one_rx", 8'hA5);

        // Burst of three back-to-back frames.
        send_burst(3, 8'h01);
        wait_idle("burst_len", 1000, 3 * FRAME + 1);
        for (int i = 1; i <= 3; i++) check_rx("burst_rx", 8'(i));

        // Overflow: 0x10..0x14 fit, 0x15 is dropped.
        ovf_cnt   = 0;
        full_seen = 1'b0;
        ovf_arm   = 1'b1;
        send_burst(6, 8'h10);
        wait_idle("ovf_len", 1000, 5 * FRAME + 1);
        ovf_arm = 1'b0;
        check("ovf_pulses", ovf_cnt, 1);
        check("ovf_full_seen", full_seen, 1);
        for (int i = 0; i < 5; i++) check_rx("ovf_rx", 8'h10 + 8'(i));
        check("ovf_rx_extra", rx_q.size(), 0);

        // Strobe while full, on the cycle the serializer pops.
        send_burst(5, 8'h20);
        check("coll_full", fifo_full, 1);
        w = 0;
        while (mpos != FRAME - 1 && w < 300) begin
            @(negedge sys_clk);
            w++;
        end
        tx_en   = 1'b1;
        tx_data = 8'h77;
        @(negedge sys_clk);
        tx_en = 1'b0;
        check("coll_ovf", overflow, 1);
        check("coll_full_after", fifo_full, 0);
        check("coll_next_start", tx, 0);
        wait_idle("coll_len", 1000, 5 * FRAME + 1);
        for (int i = 0; i < 5; i++) check_rx("coll_rx", 8'h20 + 8'(i));
        check("coll_rx_extra", rx_q.size(), 0);

        // Reset during data bit 3 of 0xFF with two bytes queued.
        send_burst(3, 8'hFF);
        repeat (43) @(negedge sys_clk);
        check("rst_mid_bit3", tx, 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_full", fifo_full, 0);
        low_cnt = 0;
        repeat (300) begin
            @(negedge sys_clk);
            if (tx == 1'b0) low_cnt++;
        end
        check("rst_mid_quiet", low_cnt, 0);
        check("rst_mid_rx", rx_q.size(), 0);
        send_burst(1, 8'h3C);
        wait_idle("rst_new_len", 1000, FRAME + 1);
        check_rx("rst_new_rx", 8'h3C);

        // Pointer wrap: ten bytes one frame apart.
        for (int i = 0; i < 10; i++) begin
            send_burst(1, 8'(i));
            if (i < 9) repeat (98) @(negedge sys_clk);
        end
        wait_idle("wrap_len", 1000, FRAME + 1);
        for (int i = 0; i < 10; i++) check_rx("wrap_rx", 8'(i));

        // Random traffic, including overflow, against the model.
        acc_q.delete();
        check("rand_rx_empty", rx_q.size(), 0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge sys_clk);
            tx_en   = ($urandom_range(0, 99) < 4);
            tx_data = 8'($urandom);
        end
        @(negedge sys_clk);
        tx_en = 1'b0;
        w = 0;
        while (busy && w < 2000) begin
            @(negedge sys_clk);
            w++;
        end
        check("rand_drain", busy, 0);
        check("rand_count", rx_q.size(), acc_q.size());
        while (rx_q.size() > 0 && acc_q.size() > 0)
            check("rand_rx", rx_q.pop_front(), acc_q.pop_front());

        repeat (5) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
